// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcodes, instruction field slices,
// sequencer state encoding and the opcode legality / immediate-extension helpers.
package alu_pkg;

    localparam logic [5:0] OP_ADD   = 6'd8;
    localparam logic [5:0] OP_ADDI  = 6'd9;
    localparam logic [5:0] OP_SUB   = 6'd10;
    localparam logic [5:0] OP_LUI   = 6'd11;
    localparam logic [5:0] OP_DIV   = 6'd12;
    localparam logic [5:0] OP_MULT  = 6'd13;
    localparam logic [5:0] OP_DIVI  = 6'd14;
    localparam logic [5:0] OP_MULTI = 6'd15;
    localparam logic [5:0] OP_SLL   = 6'd16;
    localparam logic [5:0] OP_SRA   = 6'd17;
    localparam logic [5:0] OP_SRL   = 6'd18;
    localparam logic [5:0] OP_AND   = 6'd20;
    localparam logic [5:0] OP_ANDI  = 6'd21;
    localparam logic [5:0] OP_OR    = 6'd22;
    localparam logic [5:0] OP_ORI   = 6'd23;
    localparam logic [5:0] OP_XOR   = 6'd24;
    localparam logic [5:0] OP_XORI  = 6'd25;
    localparam logic [5:0] OP_NOR   = 6'd26;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RD_MSB     = 25;
    localparam int RD_LSB     = 21;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESULT
    } seq_state_e;

    function automatic logic is_legal_op(input logic [5:0] op);
        return ((op >= OP_ADD) && (op <= OP_SRL)) || ((op >= OP_AND) && (op <= OP_NOR));
    endfunction

    // Logical-immediate forms and LUI take the raw 16 bits; everything else is signed.
    function automatic logic [31:0] imm_extend(input logic [5:0] op, input logic [15:0] imm);
        if ((op == OP_LUI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI)) begin
            return {16'h0000, imm};
        end
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu_imm_extend.sv
// Combinational immediate extension (opcode + imm16 -> 32-bit operand),
// shared by any issue stage feeding the ALU exec element.
module alu_imm_extend
    import alu_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [15:0] imm16_i,
    output logic [31:0] const16_x_o
);

    assign const16_x_o = imm_extend(opcode_i, imm16_i);

endmodule

// File: rtl/alu_issue_sequencer.sv
// Single-outstanding issue sequencer in front of AluExecElement.
// Optional WAIT watchdog enabled by defining ALU_ISSUE_TIMEOUT_EN.
module alu_issue_sequencer
    import alu_pkg::*;
#(
    parameter int LAUNCH_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        elem_reset,
    output logic [5:0]  inst_num,
    output logic [31:0] const16_x,
    output logic [4:0]  shift5,
    output logic [31:0] rs,
    output logic [31:0] rt,
    input  logic        completed,
    input  logic [31:0] out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_dest,
    output logic        res_err
);

    localparam int LCW = $clog2(LAUNCH_CYCLES + 1);

    seq_state_e  state_q, state_d;
    logic [LCW-1:0] launch_cnt_q, launch_cnt_d;
    logic [5:0]  opcode_q;
    logic [4:0]  rd_q;
    logic [15:0] imm16_q;
    logic [4:0]  shamt_q;
    logic [31:0] rs_q, rt_q;
    logic [31:0] res_data_q, res_data_d;
    logic        res_err_q, res_err_d;
    logic        accept;

    // rt field of the word is carried separately as rt_val, so its bits are not needed here.
    logic unused_inst_bits;
    assign unused_inst_bits = ^inst[20:16];

`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCW-1:0] wd_cnt_q, wd_cnt_d;
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

    assign inst_ready = !reset && (state_q == ST_IDLE);
    assign accept     = inst_ready && inst_valid;
    // The element stays parked in reset everywhere except while it is computing.
    assign elem_reset = reset || (state_q != ST_WAIT);
    assign res_valid  = !reset && (state_q == ST_RESULT);

    assign inst_num = opcode_q;
    assign shift5   = shamt_q;
    assign rs       = rs_q;
    assign rt       = rt_q;
    assign res_data = res_data_q;
    assign res_err  = res_err_q;
    assign res_dest = rd_q;

    alu_imm_extend u_imm_extend (
        .opcode_i    (opcode_q),
        .imm16_i     (imm16_q),
        .const16_x_o (const16_x)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d      = state_q;
        launch_cnt_d = launch_cnt_q;
        res_data_d   = res_data_q;
        res_err_d    = res_err_q;
`ifdef ALU_ISSUE_TIMEOUT_EN
        wd_cnt_d     = wd_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_legal_op(inst[OPCODE_MSB:OPCODE_LSB])) begin
                        state_d      = ST_LAUNCH;
                        launch_cnt_d = '0;
                    end else begin
                        state_d    = ST_RESULT;
                        res_data_d = '0;
                        res_err_d  = 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                // completed is deliberately ignored here: it may still reflect the previous op.
                if (launch_cnt_q == LCW'(LAUNCH_CYCLES - 1)) begin
                    state_d = ST_WAIT;
`ifdef ALU_ISSUE_TIMEOUT_EN
                    wd_cnt_d = '0;
`endif
                end else begin
                    launch_cnt_d = launch_cnt_q + LCW'(1);
                end
            end
            ST_WAIT: begin
                if (completed) begin
                    state_d    = ST_RESULT;
                    res_data_d = out;
                    res_err_d  = 1'b0;
                end
`ifdef ALU_ISSUE_TIMEOUT_EN
                else if (wd_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = ST_RESULT;
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + TCW'(1);
                end
`endif
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            launch_cnt_q <= '0;
            opcode_q     <= '0;
            rd_q         <= '0;
            imm16_q      <= '0;
            shamt_q      <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            res_data_q   <= '0;
            res_err_q    <= 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
            wd_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            launch_cnt_q <= launch_cnt_d;
            res_data_q   <= res_data_d;
            res_err_q    <= res_err_d;
`ifdef ALU_ISSUE_TIMEOUT_EN
            wd_cnt_q     <= wd_cnt_d;
`endif
            if (accept) begin
                opcode_q <= inst[OPCODE_MSB:OPCODE_LSB];
                rd_q     <= inst[RD_MSB:RD_LSB];
                imm16_q  <= inst[IMM_MSB:IMM_LSB];
                shamt_q  <= inst[SHAMT_MSB:SHAMT_LSB];
                rs_q     <= rs_val;
                rt_q     <= rt_val;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Randomized self-checking bench for alu_issue_sequencer with a timestamp-based
// reference model, an exec-element model, and directed literal cases.
module tb_alu_issue_sequencer;

    localparam int L   = 2;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        elem_reset;
    logic [5:0]  inst_num;
    logic [31:0] const16_x;
    logic [4:0]  shift5;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        completed;
    logic [31:0] out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_dest;
    logic        res_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;

    int comp_delay = 0;
    bit stale_mode = 0;
    bit never_complete = 0;

    alu_issue_sequencer #(.LAUNCH_CYCLES(L), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .elem_reset (elem_reset),
        .inst_num   (inst_num),
        .const16_x  (const16_x),
        .shift5     (shift5),
        .rs         (rs),
        .rt         (rt),
        .completed  (completed),
        .out        (out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_dest   (res_dest),
        .res_err    (res_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ext_ref(input logic [5:0] op, input logic [15:0] imm);
        if (op == 6'd11 || op == 6'd21 || op == 6'd23 || op == 6'd25) return {16'h0, imm};
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic bit legal_ref(input logic [5:0] op);
        return (op >= 8 && op <= 18) || (op >= 20 && op <= 26);
    endfunction

    function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] k, input logic [4:0] sh);
        case (op)
            6'd8:  return a + b;
            6'd9:  return a + k;
            6'd10: return a - b;
            6'd11: return k << 16;
            6'd12: return (b == 0) ? 32'h0 : a / b;
            6'd13: return a * b;
            6'd14: return (k == 0) ? 32'h0 : a / k;
            6'd15: return a * k;
            6'd16: return b << sh;
            6'd17: return $signed(b) >>> sh;
            6'd18: return b >> sh;
            6'd20: return a & b;
            6'd21: return a & k;
            6'd22: return a | b;
            6'd23: return a | k;
            6'd24: return a ^ b;
            6'd25: return a ^ k;
            6'd26: return ~(a | b);
            default: return 32'h0;
        endcase
    endfunction

    // Exec element model: computes from whatever operands the sequencer presents.
    initial begin
        int wcnt;
        completed = 1'b0;
        out = '0;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (elem_reset) begin
                wcnt = 0;
                completed = stale_mode;
                out = stale_mode ? 32'hbad0bad0 : $urandom;
            end else begin
                if (!never_complete && wcnt >= comp_delay) begin
                    completed = 1'b1;
                    out = alu_ref(inst_num, rs, rt, const16_x, shift5);
                end else begin
                    completed = 1'b0;
                    out = $urandom;
                end
                wcnt++;
            end
        end
    end

    // Reference model: one outstanding op described by its acceptance and finish timestamps.
    bit          busy = 0, have_op = 0, m_legal = 0, m_done = 0, prev_rst = 0, m_err = 0;
    int          t_acc = 0, t_done = 0;
    logic [31:0] m_w = '0, m_rs = '0, m_rt = '0, m_data = '0;

    always @(negedge clk) begin
        bit exp_valid, exp_er;
        if (reset) begin
            check("rst_inst_ready", {31'b0, inst_ready}, 32'd0);
            check("rst_elem_reset", {31'b0, elem_reset}, 32'd1);
            check("rst_res_valid", {31'b0, res_valid}, 32'd0);
            busy = 0;
            have_op = 0;
            prev_rst = 1;
        end else begin
            if (prev_rst) begin
                check("rst_res_data", res_data, 32'd0);
                check("rst_res_dest", {27'b0, res_dest}, 32'd0);
                check("rst_res_err", {31'b0, res_err}, 32'd0);
                check("rst_operands", rs | rt | const16_x | {26'b0, inst_num} | {27'b0, shift5}, 32'd0);
            end
            prev_rst = 0;
            if (busy && m_legal && !m_done && cyc >= t_acc + L + 1) begin
                if (completed) begin
                    m_done = 1;
                    t_done = cyc;
                    m_data = alu_ref(m_w[31:26], m_rs, m_rt, ext_ref(m_w[31:26], m_w[15:0]), m_w[10:6]);
                    m_err = 0;
                end
`ifdef ALU_ISSUE_TIMEOUT_EN
                else if (cyc == t_acc + L + TMO) begin
                    m_done = 1;
                    t_done = cyc;
                    m_data = 0;
                    m_err = 1;
                end
`endif
            end
            exp_valid = busy && m_done && cyc > t_done;
            exp_er = !(busy && m_legal && cyc >= t_acc + L + 1 && (!m_done || cyc <= t_done));
            check("inst_ready", {31'b0, inst_ready}, {31'b0, !busy});
            check("elem_reset", {31'b0, elem_reset}, {31'b0, exp_er});
            check("res_valid", {31'b0, res_valid}, {31'b0, exp_valid});
            if (exp_valid) begin
                check("res_data", res_data, m_data);
                check("res_dest", {27'b0, res_dest}, {27'b0, m_w[25:21]});
                check("res_err", {31'b0, res_err}, {31'b0, m_err});
            end
            if (have_op && cyc > t_acc) begin
                check("op_inst_num", {26'b0, inst_num}, {26'b0, m_w[31:26]});
                check("op_shift5", {27'b0, shift5}, {27'b0, m_w[10:6]});
                check("op_rs", rs, m_rs);
                check("op_rt", rt, m_rt);
                check("op_const16_x", const16_x, ext_ref(m_w[31:26], m_w[15:0]));
            end
            if (exp_valid && res_ready) begin
                busy = 0;
            end else if (!busy && inst_valid) begin
                busy = 1;
                have_op = 1;
                t_acc = cyc;
                m_w = inst;
                m_rs = rs_val;
                m_rt = rt_val;
                m_legal = legal_ref(inst[31:26]);
                m_done = !m_legal;
                t_done = cyc;
                m_data = 0;
                m_err = !m_legal;
            end
        end
    end

    task automatic offer(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        inst = w;
        rs_val = a;
        rt_val = b;
        inst_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (inst_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_wait", 32'd0, 32'd1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        inst = $urandom;
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    task automatic collect(input int bp, output logic [31:0] d, output logic e,
                           output logic [4:0] dest, output int lat);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (res_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("result_wait", 32'd0, 32'd1);
        lat = cyc - acc_cyc;
        d = res_data;
        e = res_err;
        dest = res_dest;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'b0, res_valid}, 32'd1);
            check("bp_hold_data", res_data, d);
            check("bp_inst_ready", {31'b0, inst_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        logic [4:0]  dest;
        int          lat;
        int          legal_ops [18] = '{8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 20, 21, 22, 23, 24, 25, 26};
        logic [5:0]  op;
        logic [15:0] imm;

        reset = 1'b1;
        inst_valid = 1'b0;
        inst = '0;
        rs_val = '0;
        rt_val = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // ADDI sign-extended immediate
        comp_delay = 0;
        offer({6'd9, 5'd3, 5'd0, 16'hff01}, 32'd17, 32'd99);
        @(negedge clk);
        check("addi_const16_x", const16_x, 32'hffffff01);
        collect(0, d, e, dest, lat);
        check("addi_data", d, 32'hffffff12);
        check("addi_dest", {27'b0, dest}, 32'd3);
        check("addi_err", {31'b0, e}, 32'd0);
        check("addi_latency", lat, 32'd4);

        // ORI zero-extended immediate
        offer({6'd23, 5'd9, 5'd0, 16'h8005}, 32'h3, 32'h0);
        @(negedge clk);
        check("ori_const16_x", const16_x, 32'h00008005);
        collect(0, d, e, dest, lat);
        check("ori_data", d, 32'h00008007);

        // Illegal opcode 19
        offer({6'd19, 5'd4, 5'd0, 16'h1234}, 32'd1, 32'd2);
        collect(0, d, e, dest, lat);
        check("illegal_latency", lat, 32'd1);
        check("illegal_data", d, 32'd0);
        check("illegal_err", {31'b0, e}, 32'd1);

        // MULT under back-pressure
        offer({6'd13, 5'd12, 5'd0, 16'h0}, 32'hdab, 32'heae);
        collect(10, d, e, dest, lat);
        check("mult_data", d, 32'd13149242);

        // Stale completion during LAUNCH
        stale_mode = 1;
        comp_delay = 2;
        offer({6'd8, 5'd5, 5'd0, 16'h0}, 32'd5, 32'd6);
        collect(0, d, e, dest, lat);
        check("stale_data", d, 32'd11);
        check("stale_latency", lat, 32'd6);
        stale_mode = 0;
        comp_delay = 0;

        // Reset while waiting, then a fresh SUB
        never_complete = 1;
        offer({6'd8, 5'd6, 5'd0, 16'h0}, 32'd1, 32'd1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        never_complete = 0;
        @(negedge clk);
        check("abort_no_result", {31'b0, res_valid}, 32'd0);
        offer({6'd10, 5'd7, 5'd0, 16'h0}, 32'd17, 32'd18);
        collect(0, d, e, dest, lat);
        check("sub_data", d, 32'hffffffff);
        check("sub_dest", {27'b0, dest}, 32'd7);

`ifdef ALU_ISSUE_TIMEOUT_EN
        never_complete = 1;
        offer({6'd8, 5'd2, 5'd0, 16'h0}, 32'd1, 32'd1);
        collect(0, d, e, dest, lat);
        check("timeout_err", {31'b0, e}, 32'd1);
        check("timeout_data", d, 32'd0);
        check("timeout_latency", lat, L + TMO + 1);
        never_complete = 0;
`endif

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(3) != 0) op = 6'(legal_ops[$urandom_range(17)]);
            else op = 6'($urandom_range(63));
            imm = 16'($urandom);
            comp_delay = $urandom_range(5);
            stale_mode = ($urandom_range(3) == 0);
            offer({op, 5'($urandom), 5'($urandom), imm}, $urandom, $urandom);
            collect($urandom_range(3), d, e, dest, lat);
        end
        stale_mode = 0;

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
- Issue stage directly upstream of AluExecElement.
- Accepts one decoded-format 32-bit instruction word plus register-file operand values over a valid/ready handshake.
- Drives the exec element's operand ports and its per-operation reset pulse, then waits for `completed`.
- Returns the result with its destination register index to writeback over a second valid/ready handshake. Only one operation is in flight at a time.

Parameters:
- LAUNCH_CYCLES, default 2: number of cycles `elem_reset` is held high before each operation (minimum 1).
- TIMEOUT_CYCLES, default 64: watchdog limit in WAIT; used only when ALU_ISSUE_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- inst_valid  in  1  instruction offered
- inst_ready  out  1  sequencer can accept
- inst  in  32  instruction word: [31:26] opcode, [25:21] rd, [15:0] imm16, [10:6] shift5
- rs_val  in  32  rs operand value
- rt_val  in  32  rt operand value
- elem_reset  out  1  reset/start to exec element
- inst_num  out  6  opcode to exec element
- const16_x  out  32  extended immediate
- shift5  out  5  shift amount
- rs  out  32  operand
- rt  out  32  operand
- completed  in  1  exec element done (level)
- out  in  32  exec element result
- res_valid  out  1  result available
- res_ready  in  1  writeback accepts
- res_data  out  32  result
- res_dest  out  5  rd of the operation
- res_err  out  1  illegal opcode or timeout

Behaviour:
- Reset values: inst_ready=0 while reset is high, elem_reset=1, res_valid=0, res_data=0, res_dest=0, res_err=0. Operand outputs are 0.
- Reset mid-operation abandons the operation with no result, and the FSM returns to IDLE.
- FSM states: IDLE, LAUNCH, WAIT, RESULT.
- IDLE:
  - inst_ready=1, and elem_reset is held at 1.
  - On inst_valid&inst_ready, register inst fields, rs_val and rt_val.
  - Legal opcode → go to LAUNCH with the launch counter cleared.
  - Illegal opcode → go to RESULT with res_data=0 and res_err=1; the element is not started.
- Legal opcodes: 8–16, 17, 18, 20–26. Everything else is illegal.
- const16_x extension:
  - Zero-extend imm16 for opcodes 11, 21, 23, 25.
  - Sign-extend imm16 for all other opcodes.
- Operand outputs are held stable from LAUNCH until the next acceptance.
- LAUNCH:
  - elem_reset=1 for exactly LAUNCH_CYCLES cycles, then go to WAIT.
  - `completed` is ignored in LAUNCH, so a stale completion cannot be taken.
- WAIT:
  - elem_reset=0.
  - On the first cycle with completed=1, capture `out` into res_data, then go to RESULT with res_err=0.
- RESULT:
  - res_valid=1; res_data, res_dest and res_err are held stable.
  - On res_ready, go to IDLE; inst_ready rises on the next cycle.
  - No new instruction is accepted in the same cycle as the result transfer.
- Latency: with acceptance at cycle T, elem_reset is high for T+1..T+LAUNCH_CYCLES. If completed is first high at cycle C, res_valid=1 from C+1.
- Illegal opcode: res_valid=1 at T+1.
- Back-pressure: res_ready=0 holds RESULT indefinitely with outputs unchanged.

Optional Feature:
- Macro: ALU_ISSUE_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT. If TIMEOUT_CYCLES cycles elapse without `completed`, go to RESULT with res_data=0, res_err=1, and elem_reset reasserted. If completed and timeout occur in the same cycle, completed wins.
- Undefined: no counter; WAIT waits forever, and res_err reports only illegal opcodes.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD=8, OP_ADDI=9, OP_SUB=10, OP_LUI=11, OP_DIV=12, OP_MULT=13, OP_DIVI=14, OP_MULTI=15, OP_SLL=16, OP_SRA=17, OP_SRL=18, OP_AND=20 … OP_NOR=26)
  - the instruction field-slice constants
  - the FSM state enum
  - the function is_legal_op and an imm-extension function
- Sub-module alu_imm_extend (combinational opcode+imm16 → const16_x) is natural, for reuse by other issue stages.

Test Plan:
- ADDI: opcode 9, rd=3, imm16=16'hff01, rs_val=17 → const16_x=32'hffffff01, elem_reset high for 2 cycles. With the bench element completing, res_data=17-255, res_dest=3, res_err=0.
- ORI zero-extend: opcode 23, imm16=16'h8005, rs_val=4'b0011 → const16_x=32'h00008005, res_data=32'h00008007.
- Illegal opcode 19: no elem_reset deassertion, and res_valid at T+1 with res_data=0, res_err=1.
- Back-pressure: MULT with rs=32'hdab, rt=32'heae; hold res_ready=0 for 10 cycles → res_valid stays 1 with res_data=13149242 stable, and inst_ready=0 throughout.
- Stale completed: hold completed=1 during LAUNCH → ignored. Result is taken only after elem_reset falls, and res_data equals `out` from the WAIT cycle.
- Reset in WAIT, then issue SUB 17-18 → no result from the aborted operation, and the new result is 32'hffffffff. Additionally, with ALU_ISSUE_TIMEOUT_EN defined, never asserting completed gives res_err=1 after 64 WAIT cycles.
